// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer beside the EX-stage ALU: shift-add multiply, restoring divide.
// Optional MULDIV_EARLY_OUT_EN: trivial ops (divide by zero, signed overflow, zero multiply) finish in one cycle.
module muldiv_sequencer #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   divisor;
  logic [2*WIDTH-1:0] acc;

  // Sign correction applied to the unsigned iteration result in the final cycle.
  function automatic logic [WIDTH-1:0] finalize(input logic [2:0] f3,
                                                input logic [2*WIDTH-1:0] acc_v,
                                                input logic nq, input logic nr);
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    prod = nq ? -acc_v : acc_v;
    quo  = nq ? -acc_v[WIDTH-1:0] : acc_v[WIDTH-1:0];
    rem  = nr ? -acc_v[2*WIDTH-1:WIDTH] : acc_v[2*WIDTH-1:WIDTH];
    case (f3)
      3'b000:                 finalize = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: finalize = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         finalize = quo;
      default:                finalize = rem;
    endcase
  endfunction

  logic             a_signed, b_signed, sa, sb, b_zero, is_div;
  logic [WIDTH-1:0] abs_a, abs_b;

  always_comb begin
    is_div   = funct3[2];
    a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    b_signed = (funct3 == 3'b000) || (funct3 == 3'b001) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    sa       = a_signed && opA[WIDTH-1];
    sb       = b_signed && opB[WIDTH-1];
    abs_a    = sa ? -opA : opA;
    abs_b    = sb ? -opB : opB;
    b_zero   = (opB == '0);
  end

  // One iteration: acc holds {hi, lo}; multiply shifts right, divide shifts left.
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_next, div_next, acc_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, divisor};
    mul_next  = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, divisor};
    div_ge    = !div_diff[WIDTH];
    div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 acc[WIDTH-2:0], div_ge};
    acc_next  = op[2] ? div_next : mul_next;
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic             early_hit;
  logic [WIDTH-1:0] early_result;

  always_comb begin
    early_hit    = 1'b0;
    early_result = '0;
    if (is_div) begin
      if (b_zero) begin
        early_hit    = 1'b1;
        early_result = funct3[1] ? opA : '1;
      end else if (!funct3[0] && (opA == {1'b1, {(WIDTH-1){1'b0}}}) && (&opB)) begin
        early_hit    = 1'b1;
        early_result = funct3[1] ? '0 : opA;
      end
    end else if ((opA == '0) || b_zero) begin
      early_hit    = 1'b1;
      early_result = '0;
    end
  end
`endif

  assign stall = ((state == IDLE) && start && !flush) || (state == BUSY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op      <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      divisor <= '0;
      acc     <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      result  <= '0;
    end else if (flush) begin
      state <= IDLE;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op      <= funct3;
            neg_q   <= (sa ^ sb) && !(is_div && b_zero);
            neg_r   <= sa;
            cnt     <= '0;
            acc     <= {{WIDTH{1'b0}}, abs_a};
            divisor <= abs_b;
            busy    <= 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
            if (early_hit) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= early_result;
            end else begin
              state <= BUSY;
            end
`else
            state <= BUSY;
`endif
          end
        end
        BUSY: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= finalize(op, acc_next, neg_q, neg_r);
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic results, latency, stall, flush and async reset.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  funct3;
  logic [31:0] opA, opB;
  logic        stall, busy, done;
  logic [31:0] result;

  int checks = 0;
  int fails  = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 33;
`endif

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .opA(opA), .opB(opB), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Issues one op on a negedge; lat = cycles from start cycle to done cycle, stalls = stall-high cycles.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic hold_start,
                       output logic [31:0] res, output int lat, output int stalls);
    @(negedge clk);
    funct3 = f3; opA = a; opB = b; start = 1'b1;
    #1;
    lat = 0; res = '0;
    stalls = stall ? 1 : 0;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    else opA = a + 32'd2;
    for (int i = 1; i <= 100; i++) begin
      #1;
      if (done) begin
        lat = i; res = result; start = 1'b0;
        break;
      end
      if (stall) stalls++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; opA = '0; opB = '0;
    repeat (2) @(negedge clk);
    #1;
    if ({busy, done, stall} !== 3'b000) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 000", {busy, done, stall});
    end
    checks++;
    if (result !== 32'h0) begin
      fails++; $display("FAIL reset_result: got %h expected 00000000", result);
    end
    checks++;
    reset = 1'b0;
  endtask

  task automatic test_mul;
    logic [31:0] r; int lat, st;
    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0, r, lat, st);
    check32("mul_7x-3", r, 32'hFFFF_FFEB);
    check_int("mul_latency", lat, 33);
    check_int("mul_stall_cycles", st, 33);
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r, lat, st);
    check32("mulhu", r, 32'hFFFF_FFFE);
    do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r, lat, st);
    check32("mulh", r, 32'h0000_0000);
    do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r, lat, st);
    check32("mulhsu", r, 32'hFFFF_FFFF);
    do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 1'b0, r, lat, st);
    check32("mulh_minxmin", r, 32'h4000_0000);
  endtask

  task automatic test_div;
    logic [31:0] r; int lat, st;
    do_op(3'b100, 32'hFFFF_FFEC, 32'd6, 1'b0, r, lat, st);
    check32("div_-20/6", r, 32'hFFFF_FFFD);
    check_int("div_latency", lat, 33);
    do_op(3'b110, 32'hFFFF_FFEC, 32'd6, 1'b0, r, lat, st);
    check32("rem_-20%6", r, 32'hFFFF_FFFE);
    do_op(3'b101, 32'd100, 32'd7, 1'b0, r, lat, st);
    check32("divu_100/7", r, 32'd14);
    do_op(3'b111, 32'd100, 32'd7, 1'b0, r, lat, st);
    check32("remu_100%7", r, 32'd2);
  endtask

  task automatic test_special;
    logic [2:0]  f3s [5] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b110};
    logic [31:0] as  [5] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [31:0] bs  [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] exp [5] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFF9};
    logic [31:0] r; int lat, st;
    for (int i = 0; i < 5; i++) begin
      do_op(f3s[i], as[i], bs[i], 1'b0, r, lat, st);
      check32($sformatf("special%0d_result", i), r, exp[i]);
      check_int($sformatf("special%0d_latency", i), lat, SPECIAL_LAT);
      check_int($sformatf("special%0d_stall", i), st, SPECIAL_LAT);
    end
  endtask

  task automatic test_flush;
    logic [31:0] r; int lat, st; logic saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    funct3 = 3'b101; opA = 32'd1000; opB = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) begin
      #1; saw_done |= done;
      @(negedge clk);
    end
    flush = 1'b1;
    #1; saw_done |= done;
    @(negedge clk);
    flush = 1'b0;
    #1;
    if ({stall, busy, done} !== 3'b000) begin
      fails++; $display("FAIL flush_idle: got stall/busy/done %b expected 000", {stall, busy, done});
    end
    checks++;
    repeat (30) begin
      @(negedge clk); #1; saw_done |= done;
    end
    check_int("flush_no_done", int'(saw_done), 0);
    do_op(3'b000, 32'd3, 32'd4, 1'b0, r, lat, st);
    check32("mul_after_flush", r, 32'd12);
    check_int("mul_after_flush_lat", lat, 33);
  endtask

  task automatic test_start_held;
    logic [31:0] r; int lat, st;
    do_op(3'b000, 32'd7, 32'd5, 1'b1, r, lat, st);
    check32("start_held_result", r, 32'd35);
    check_int("start_held_latency", lat, 33);
  endtask

  task automatic test_async_reset;
    logic saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    funct3 = 3'b101; opA = 32'd1000; opB = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check_int("busy_before_reset", int'(busy), 1);
    check32("result_held_before_reset", result, 32'd35);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    if ({busy, done} !== 2'b00 || result !== 32'h0) begin
      fails++;
      $display("FAIL async_reset: got busy=%b done=%b result=%h expected 0 0 00000000",
               busy, done, result);
    end
    checks++;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) begin
      @(negedge clk); #1; saw_done |= done;
    end
    check_int("reset_no_done", int'(saw_done), 0);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_start_held();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for RV32M multiply/divide ops, attached beside the EX-stage ALU of the 5-stage pipeline.
- Accepts one op from EX and stalls the pipeline while an iterative shift-add multiplier or restoring divider runs.
- Returns a single-cycle done pulse with the result for EX/MEM capture.
- Decode selects it when opcode is OP and funct7=0000001; the ALU controller is bypassed for these ops.

Parameters:
WIDTH, 32, operand/result width in bits; must be even and at least 8.
CNT_W, $clog2(WIDTH), width of the iteration counter; derived, not overridden.

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  EX presents a valid M-extension op this cycle
funct3  input  3  RV32M op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
opA  input  WIDTH  rs1 operand
opB  input  WIDTH  rs2 operand
flush  input  1  pipeline flush (branch mispredict/trap); aborts the op in flight
stall  output  1  hold IF/ID/EX; combinational: (state==IDLE && start && !flush) || state==BUSY
busy  output  1  registered; high in BUSY and DONE
done  output  1  registered one-cycle pulse; result valid
result  output  WIDTH  registered result; held until the next accepted start

Behaviour:
- Reset (async): state=IDLE, counter=0, done=0, busy=0, result=0, internal accumulators=0. Reset mid-op discards the op and produces no done.
- States: IDLE -> BUSY on start&&!flush. BUSY -> DONE when counter==WIDTH-1. DONE -> IDLE unconditionally. Any state -> IDLE on flush; flush has priority over start and completion.
- Accept: op latched only in IDLE. Latch funct3, sign flags and absolute operand values; counter=0. start in BUSY/DONE is ignored; EX is stalled, so it re-presents the op.
- Latency: start accepted in cycle N -> done=1 in cycle N+WIDTH+1. stall is high cycles N..N+WIDTH and low in the done cycle, so EX advances exactly when result is valid.
- Signed handling: MUL/MULH/DIV/REM take |opA| and |opB|. MULHSU takes |opA| and raw opB. The U-variants use raw operands. Iterate unsigned; negate in the final cycle when the sign flags differ (remainder takes the dividend's sign).
- Multiply: 2*WIDTH-bit product, one shift-add per cycle. MUL returns product[WIDTH-1:0]; MULH/MULHSU/MULHU return product[2*WIDTH-1:WIDTH].
- Divide: restoring, one quotient bit per cycle. DIV/DIVU return the quotient; REM/REMU return the remainder.
- Divide by zero: quotient = all ones (-1); remainder = opA. No trap.
- Signed overflow (DIV, opA=most-negative, opB=-1): quotient = opA; REM result = 0.
- done is high only in DONE. result updates on the DONE-entry edge and holds through IDLE.
- flush in the done cycle: done still pulses (already registered), state goes to IDLE, and EX discards it.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: in IDLE, if start and (divide by zero, signed overflow, or multiply with opA==0 or opB==0), go directly IDLE -> DONE. done is high in cycle N+1 and stall is high only in cycle N. Result values are identical to the full path.
- Undefined: every op takes the full WIDTH+1-cycle latency. Special cases are resolved by the final-cycle correction.

Test Plan:
- MUL opA=7, opB=-3 (0xFFFFFFFD), start one cycle -> stall high 33 cycles, done in cycle N+33, result=0xFFFFFFEB.
- MULHU opA=0xFFFFFFFF, opB=0xFFFFFFFF -> result=0xFFFFFFFE. MULH on the same operands -> result=0x00000000. MULHSU opA=-1, opB=0xFFFFFFFF -> result=0xFFFFFFFF.
- DIV opA=-20, opB=6 -> result=0xFFFFFFFD (-3). REM on the same operands -> 0xFFFFFFFE (-2). DIVU opA=100, opB=7 -> 14.
- DIVU opA=5, opB=0 -> 0xFFFFFFFF. REMU -> 5. DIV opA=0x80000000, opB=0xFFFFFFFF -> 0x80000000, and REM -> 0. Run each with and without MULDIV_EARLY_OUT_EN: defined gives done in cycle N+1, undefined gives N+33.
- DIVU starts, flush asserted in BUSY cycle 10 -> state IDLE next cycle, stall low, no done pulse. New MUL 3*4 accepted immediately -> result=12.
- Async reset asserted mid-BUSY (between clock edges) -> busy, done and result all 0 immediately. start held high during BUSY is ignored: no restart, and result matches the first op.
